// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master to one-port SRAM-like arbiter, one transaction outstanding
module sram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state, state_next;
  logic        owner_data;
  logic        last_data;
  logic        grant_data;
  logic        any_req;
  logic        cap_wr;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        port_addr_ok;
  logic        port_data_ok;

  assign any_req    = inst_req | data_req;
  // Data wins a tie unless it also won the previous grant.
  assign grant_data = data_req & (~inst_req | ~last_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      last_data  <= 1'b0;
      cap_wr     <= 1'b0;
      cap_size   <= 2'd0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        owner_data <= grant_data;
        last_data  <= grant_data;
        cap_wr     <= grant_data ? data_wr    : inst_wr;
        cap_size   <= grant_data ? data_size  : inst_size;
        cap_addr   <= grant_data ? data_addr  : inst_addr;
        cap_wdata  <= grant_data ? data_wdata : inst_wdata;
      end
    end
  end

  always_comb begin
    state_next   = state;
    req          = 1'b0;
    port_addr_ok = 1'b0;
    port_data_ok = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_next = ADDR;
      end
      ADDR: begin
        req = 1'b1;
        if (addr_ok) begin
          port_addr_ok = 1'b1;
          if (data_ok) begin
            port_data_ok = 1'b1;
            state_next   = IDLE;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (data_ok) begin
          port_data_ok = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr    = cap_wr;
  assign size  = cap_size;
  assign addr  = cap_addr;
  assign wdata = cap_wdata;

  assign inst_addr_ok = port_addr_ok & ~owner_data;
  assign inst_data_ok = port_data_ok & ~owner_data;
  assign data_addr_ok = port_addr_ok &  owner_data;
  assign data_data_ok = port_data_ok &  owner_data;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 inst_req/inst_wr  input  1/1  fetch-side request, write flag; requester holds all inst_* fields stable from req=1 until inst_addr_ok=1.
REQ-005 inst_size/inst_addr/inst_wdata  input  2/32/32  fetch-side size (0=byte, 1=half, 2=word), address, write data.
REQ-006 inst_addr_ok/inst_data_ok  output  1/1  fetch-side address-accept pulse and data-return pulse.
REQ-007 inst_rdata  output  32  fetch-side read data, valid when inst_data_ok=1.
REQ-008 data_req/data_wr/data_size/data_addr/data_wdata  input  1/1/2/32/32  load/store-side request; same stability rule as REQ-004.
REQ-009 data_addr_ok/data_data_ok/data_rdata  output  1/1/32  load/store-side responses, as REQ-006/REQ-007.
REQ-010 req/wr/size/addr/wdata  output  1/1/2/32/32  shared SRAM-like port request.
REQ-011 addr_ok/data_ok/rdata  input  1/1/32  shared port address accept, data return, read data.

Function
- REQ-012 One transaction outstanding on the shared port at any time.
- REQ-013 FSM states: IDLE, ADDR, DATA; reset state IDLE.
- REQ-014 IDLE: if either requester asserts req, the arbiter registers the grant owner and the owner's wr/size/addr/wdata, then moves to ADDR next cycle; with no request, it stays in IDLE.
- REQ-015 Grant priority: with only one requester active, that requester wins. With both active, data wins unless the previous grant went to data, in which case inst wins. The last-grant register resets to inst.
- REQ-016 ADDR: req=1 and wr/size/addr/wdata are driven from the captured registers. When addr_ok=1, the owner's addr_ok output is 1 in the same cycle (combinational) and the FSM moves to DATA.
- REQ-017 ADDR with addr_ok=1 and data_ok=1 in the same cycle: both owner pulses are asserted that cycle, rdata is forwarded, and the FSM returns to IDLE.
- REQ-018 DATA: req=0. When data_ok=1, the owner's data_ok output is 1 and the owner's rdata equals rdata in the same cycle, and the FSM moves to IDLE.
- REQ-019 The non-owner's addr_ok/data_ok outputs are always 0. data_ok in IDLE, or in ADDR without addr_ok, is ignored.
- REQ-020 inst_rdata and data_rdata are both driven from rdata at all times. Only the *_data_ok pulse qualifies them.
- REQ-021 Minimum transaction: request seen in IDLE at cycle N, addr_ok/data_ok in cycle N+1, requester may issue its next req sampled in IDLE at cycle N+2.
- REQ-022 A requester dropping req before addr_ok is a protocol violation; the arbiter still completes the captured transaction.
- REQ-023 The captured fields remain unchanged from grant until return to IDLE.

Reset
- REQ-024 While reset=1 at posedge: state goes to IDLE, last-grant to inst, and captured registers to 0.
- REQ-025 After reset: req=0, and inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok are all 0.
- REQ-026 Reset in ADDR or DATA abandons the transaction without response pulses. A data_ok arriving after reset is ignored per REQ-019.

Verification
- REQ-027 Single inst read: inst_req=1, addr=0xBFC00000, addr_ok one cycle after ADDR entry, data_ok with rdata=0x3C1D0001 two cycles later -> one inst_addr_ok pulse, one inst_data_ok pulse with inst_rdata=0x3C1D0001, and data_* outputs stay 0.
- REQ-028 Simultaneous requests from reset: inst_req and data_req held, with immediate addr_ok/data_ok -> grant order data, inst, data, inst; each completes before the next req on the port.
- REQ-029 Store with immediate response: data_req=1, wr=1, size=2, addr=0x1000, wdata=0xDEADBEEF, addr_ok=data_ok=1 in the first ADDR cycle -> port shows wr=1, addr=0x1000, wdata=0xDEADBEEF; data_addr_ok and data_data_ok both pulse that cycle, and the FSM is in IDLE next cycle.
- REQ-030 Back-pressure: addr_ok held 0 for 5 cycles in ADDR -> req stays 1 with constant addr/wdata, no owner pulses, and the second requester is not granted.
- REQ-031 Reset mid-transaction: reset asserted in DATA, data_ok=1 on the following cycle -> no data_ok pulse to either requester, req=0, and the FSM is in IDLE.
